// File: rtl/mem_arb_pkg.sv
// Shared definitions for the MEM-stage data RAM arbiter: FSM state encoding,
// default widths and the starvation-guard threshold.
package mem_arb_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle = 2'd0;
  localparam arb_state_t StPend = 2'd1;
  localparam arb_state_t StResp = 2'd2;

  // Default geometry of the data RAM.
  localparam int unsigned ADDR_W_DEF = 6;
  localparam int unsigned DATA_W_DEF = 32;

  // Host-pending cycles lost to the CPU before the host is forced through.
  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned CNT_W_DEF    = 4;

  // The host owns the RAM this cycle: it is pending and either the CPU is
  // idle or the starvation guard has expired.
  function automatic logic host_wins(input logic in_pend, input logic cpu_req,
                                     input logic guard_expired);
    return in_pend & (~cpu_req | guard_expired);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter for the host starvation guard. Clear has priority
// over enable; the count holds once it reaches MAX_VAL and never wraps.
module arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned MAX_VAL = MAX_WAIT_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_max
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_VAL);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_cnt    = r_cnt;
  assign o_at_max = (r_cnt == MaxVal);

  // Next count: clear, or saturating increment when enabled.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_en && !o_at_max) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-port data RAM behind the MEM stage. The CPU
// MEM stage has priority; a debug/host port gets the RAM in CPU-idle cycles.
// Optional build macro ARB_STARVE_GUARD_EN adds a wait counter that forces the
// host through after MAX_WAIT lost cycles, stalling the CPU for that one cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  // MEM stage
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_stall,
  // Host port
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ready,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  // Data RAM
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > (2 ** CNT_W) - 1) begin : g_bad_max_wait
    $error("MAX_WAIT must lie in 1..2**CNT_W-1");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;

  logic              r_host_we;
  logic [ADDR_W-1:0] r_host_addr;
  logic [DATA_W-1:0] r_host_wdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_in_idle;
  logic              w_in_pend;
  logic              w_in_resp;
  logic              w_accept;
  logic              w_guard_expired;
  logic              w_host_win;
  logic              w_ram_we;

  assign w_in_idle = (r_state == StIdle);
  assign w_in_pend = (r_state == StPend);
  assign w_in_resp = (r_state == StResp);
  assign w_accept  = w_in_idle & i_dbg_req;

`ifdef ARB_STARVE_GUARD_EN
  logic [CNT_W-1:0] w_wait_cnt;

  // Counts pending cycles the host loses to the CPU; cleared on acceptance.
  arb_wait_counter #(
    .CNT_W  (CNT_W),
    .MAX_VAL(MAX_WAIT)
  ) u_wait_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_accept),
    .i_en    (w_in_pend & ~w_host_win),
    .o_cnt   (w_wait_cnt),
    .o_at_max(w_guard_expired)
  );

  // The wait counter saturates at the guard threshold.
  a_wait_cnt_bounded : assert property (@(posedge i_clk) disable iff (!i_reset)
    w_wait_cnt <= CNT_W'(MAX_WAIT));

  // A forced grant costs the CPU a single cycle.
  a_stall_single : assert property (@(posedge i_clk) disable iff (!i_reset)
    o_cpu_stall |=> !o_cpu_stall);
`else
  // Without the guard the host only ever gets CPU-idle cycles.
  assign w_guard_expired = 1'b0;
`endif

  assign w_host_win = host_wins(w_in_pend, i_cpu_req, w_guard_expired);

  // Next-state logic: IDLE -> PEND on accept, PEND -> RESP on a win, then back.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_dbg_req)  w_state_nxt = StPend;
      StPend:  if (w_host_win) w_state_nxt = StResp;
      StResp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the host request on acceptance; the host inputs are free after that.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_host_we    <= 1'b0;
      r_host_addr  <= '0;
      r_host_wdata <= '0;
    end else if (w_accept) begin
      r_host_we    <= i_dbg_we;
      r_host_addr  <= i_dbg_addr;
      r_host_wdata <= i_dbg_wdata;
    end
  end

  // Hold the last host read result after the ack cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_dbg_rdata <= '0;
    end else if (w_in_resp && !r_host_we) begin
      r_dbg_rdata <= i_ram_rdata;
    end
  end

  // RAM port mux: host fields in a host-win cycle, MEM-stage fields otherwise.
  always_comb begin
    o_ram_addr  = i_cpu_addr;
    o_ram_wdata = i_cpu_wdata;
    w_ram_we    = i_cpu_req & i_cpu_we;
    o_cpu_stall = 1'b0;
    if (w_host_win) begin
      o_ram_addr  = r_host_addr;
      o_ram_wdata = r_host_wdata;
      w_ram_we    = r_host_we;
`ifdef ARB_STARVE_GUARD_EN
      o_cpu_stall = i_cpu_req;
`endif
    end
  end

  // No RAM write can leak out while reset is held.
  assign o_ram_we    = i_reset & w_ram_we;

  assign o_dbg_ready = w_in_idle;
  assign o_dbg_ack   = w_in_resp;
  // Read data is visible during the ack cycle straight from the RAM.
  assign o_dbg_rdata = (w_in_resp && !r_host_we) ? i_ram_rdata : r_dbg_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: CPU pass-through vector table,
// host transactions with a read-data scoreboard, guard/no-guard starvation,
// reset during a pending request and a held-high host request.
module tb_mem_port_arbiter;

  localparam logic [5:0] CPU_X = 6'd40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [5:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_stall;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [5:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_ready, dbg_ack;
  logic [31:0] dbg_rdata;
  logic [5:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  logic [31:0] mem [64] = '{default: '0};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        req;
    logic        we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        exp_we;
  } vec_t;
  vec_t vecs[5];

  mem_port_arbiter u_dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_cpu_req  (cpu_req),
    .i_cpu_we   (cpu_we),
    .i_cpu_addr (cpu_addr),
    .i_cpu_wdata(cpu_wdata),
    .o_cpu_stall(cpu_stall),
    .i_dbg_req  (dbg_req),
    .i_dbg_we   (dbg_we),
    .i_dbg_addr (dbg_addr),
    .i_dbg_wdata(dbg_wdata),
    .o_dbg_ready(dbg_ready),
    .o_dbg_ack  (dbg_ack),
    .o_dbg_rdata(dbg_rdata),
    .o_ram_addr (ram_addr),
    .o_ram_we   (ram_we),
    .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One host transaction starting in IDLE, just after a rising edge. Cycle 0
  // presents the request; cycle i is i cycles after the acceptance edge.
  task automatic host_txn(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int busy, input int hold,
                          input int ncyc, input int exp_first_ack, input int exp_acks,
                          input int exp_stall_cyc);
    int          first_ack = -1;
    int          acks = 0;
    int          stalls = 0;
    int          stall_cyc = -1;
    logic [31:0] cpu_data = 32'hC000_0000;
    logic [31:0] stall_data = '0;
    logic        chk_mem = 1'b0;
    logic        held_chk = 1'b0;
    logic [31:0] held_val = '0;
    exp_t        e;
    for (int i = 0; i <= ncyc; i++) begin
      dbg_req   = (i <= hold);
      dbg_we    = we;
      dbg_addr  = addr;
      dbg_wdata = wd;
      cpu_req   = (i >= 1 && i <= busy);
      cpu_we    = 1'b1;
      cpu_addr  = CPU_X;
      cpu_wdata = cpu_data;
      @(negedge clk);
      if (i == 0) check("ready at request", 32'(dbg_ready), 1);
      if (i == 1) check("ready low while pending", 32'(dbg_ready), 0);
      if (chk_mem) begin
        check("stalled cpu write dropped", mem[CPU_X], stall_data - 1);
        chk_mem = 1'b0;
      end
      if (held_chk && !dbg_ack) begin
        check("dbg_rdata held after ack", dbg_rdata, held_val);
        held_chk = 1'b0;
      end
      if (dbg_req && dbg_ready) sb_q.push_back('{we, exp_rd});
      if (dbg_ack) begin
        acks++;
        if (first_ack < 0) first_ack = i;
        if (sb_q.size() == 0) begin
          check("ack without request", 32'(dbg_ack), 0);
        end else begin
          e = sb_q.pop_front();
          if (!e.we) begin
            check("dbg_rdata at ack", dbg_rdata, e.data);
            held_chk = 1'b1;
            held_val = e.data;
          end
        end
      end
      if (cpu_stall) begin
        stalls++;
        stall_cyc = i;
        check("stall cycle ram_we", 32'(ram_we), 32'(we));
        check("stall cycle ram_addr", 32'(ram_addr), 32'(addr));
        stall_data = cpu_data;
        chk_mem = 1'b1;
      end else if (cpu_req) begin
        cpu_data++;
      end
      @(posedge clk);
      #1;
    end
    dbg_req = 1'b0;
    cpu_req = 1'b0;
    check("first ack cycle", first_ack, exp_first_ack);
    check("ack count", acks, exp_acks);
    check("stall count", stalls, (exp_stall_cyc >= 0) ? 1 : 0);
    check("stall cycle", stall_cyc, exp_stall_cyc);
    check("scoreboard drained", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 6'd3,  32'h1111_1111, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 6'd7,  32'h2222_2222, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 6'd20, 32'h3333_3333, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 6'd63, 32'hA5A5_5A5A, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 6'd0,  32'hFFFF_FFFF, 1'b0};

    // Reset held with the CPU trying to write.
    rst_n     = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 6'd3;
    cpu_wdata = 32'h5555_5555;
    repeat (2) @(negedge clk);
    check("reset dbg_ready", 32'(dbg_ready), 1);
    check("reset ram_we", 32'(ram_we), 0);
    check("reset dbg_ack", 32'(dbg_ack), 0);
    check("reset dbg_rdata", dbg_rdata, 0);
    check("reset cpu_stall", 32'(cpu_stall), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CPU pass-through in IDLE.
    foreach (vecs[k]) begin
      cpu_req   = vecs[k].req;
      cpu_we    = vecs[k].we;
      cpu_addr  = vecs[k].addr;
      cpu_wdata = vecs[k].wdata;
      @(negedge clk);
      check("vec ram_we", 32'(ram_we), 32'(vecs[k].exp_we));
      check("vec ram_addr", 32'(ram_addr), 32'(vecs[k].addr));
      check("vec ram_wdata", ram_wdata, vecs[k].wdata);
      check("vec cpu_stall", 32'(cpu_stall), 0);
      check("vec dbg_ready", 32'(dbg_ready), 1);
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;

    // Idle CPU: host write then read back.
    host_txn(1'b1, 6'd5, 32'hDEAD_BEEF, '0, 0, 0, 3, 2, 1, -1);
    host_txn(1'b0, 6'd5, '0, 32'hDEAD_BEEF, 0, 0, 3, 2, 1, -1);
    check("vec write landed", mem[3], 32'h1111_1111);

    // CPU busy for 3 cycles: access in cycle 4, ack in cycle 5.
    host_txn(1'b0, 6'd5, '0, 32'hDEAD_BEEF, 3, 0, 6, 5, 1, -1);

    // CPU busy continuously.
`ifdef ARB_STARVE_GUARD_EN
    host_txn(1'b0, 6'd5, '0, 32'hDEAD_BEEF, 40, 0, 20, 17, 1, 16);
`else
    host_txn(1'b0, 6'd5, '0, 32'hDEAD_BEEF, 100, 0, 103, 102, 1, -1);
`endif

    // Reset pulsed while a host write to address 9 is pending.
    dbg_req   = 1'b1;
    dbg_we    = 1'b1;
    dbg_addr  = 6'd9;
    dbg_wdata = 32'h1234_5678;
    cpu_req   = 1'b0;
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    cpu_addr = 6'd9;
    repeat (2) begin
      @(negedge clk);
      check("pending dbg_ready", 32'(dbg_ready), 0);
      @(posedge clk);
      #1;
    end
    rst_n     = 1'b0;
    cpu_we    = 1'b1;
    cpu_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("mid reset dbg_ready", 32'(dbg_ready), 1);
    check("mid reset ram_we", 32'(ram_we), 0);
    check("mid reset dbg_ack", 32'(dbg_ack), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no ack after reset", 32'(dbg_ack), 0);
      check("no stall after reset", 32'(cpu_stall), 0);
      @(posedge clk);
      #1;
    end
    check("ram unchanged by dropped write", mem[9], 0);
    check("ready after reset", 32'(dbg_ready), 1);
    host_txn(1'b1, 6'd9, 32'h1234_5678, '0, 0, 0, 3, 2, 1, -1);
    host_txn(1'b0, 6'd9, '0, 32'h1234_5678, 0, 0, 3, 2, 1, -1);

    // Request held high through PEND/RESP: one ack, re-accepted only in IDLE.
    host_txn(1'b1, 6'd12, 32'h0BAD_F00D, '0, 0, 3, 6, 2, 2, -1);
    host_txn(1'b0, 6'd12, '0, 32'h0BAD_F00D, 0, 0, 3, 2, 1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
